// File: rtl/square_anim_pkg.sv
// Shared types and constants for the square animator.
package square_anim_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [2:0] {
        INIT,
        DRAW,
        DRAW_REL,
        WAIT_TICK,
        ERASE,
        ERASE_REL,
        UPDATE
    } state_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running move-tick generator: one-cycle pulse every FRAME_TICKS cycles.
module frame_tick_gen #(
    parameter int FRAME_TICKS = 833333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] count;

    // Count 0..FRAME_TICKS-1 and wrap, independent of the animator state.
    always_ff @(posedge clk) begin
        if (reset)              count <= '0;
        else if (count == LAST) count <= '0;
        else                    count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/square_animator.sv
// Moves one square around the screen: per tick, erase the old position,
// step with edge bounce, then redraw, all through the drawer start/done handshake.
module square_animator
    import square_anim_pkg::*;
#(
    parameter int SIZE        = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int FRAME_TICKS = 833333,
    parameter int STEP        = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               draw_done,
    output logic               draw_start,
    output logic [COORD_W-1:0] draw_x0,
    output logic [COORD_W-1:0] draw_y0,
    output logic               color,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               busy,
    output logic [15:0]        frame_count
);

    // Limits and step held at 12 bits so pos+STEP can never wrap in compares.
    localparam logic [COORD_W:0]   XMAX   = (COORD_W+1)'(SCREEN_W - 1 - SIZE);
    localparam logic [COORD_W:0]   YMAX   = (COORD_W+1)'(SCREEN_H - 1 - SIZE);
    localparam logic [COORD_W:0]   STEP_W = (COORD_W+1)'(STEP);
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

    state_t state, state_next;
    logic   tick;
    logic   tick_pending;
    logic   first_draw;
    logic   dir_x, dir_y;
    logic   dir_x_next, dir_y_next;
    logic [COORD_W-1:0] pos_x_next, pos_y_next;

    frame_tick_gen #(.FRAME_TICKS(FRAME_TICKS)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // The drawer derives its end corner from these, so pos must not move mid-pass.
    assign draw_x0 = pos_x;
    assign draw_y0 = pos_y;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    // Next-state and handshake outputs; every pass waits for done to clear
    // before the next start so a stale done is never mistaken for completion.
    always_comb begin
        state_next = state;
        draw_start = 1'b0;
        color      = 1'b1;
        busy       = 1'b1;
        case (state)
            INIT:      if (!draw_done) state_next = DRAW;
            DRAW: begin
                draw_start = 1'b1;
                if (draw_done) state_next = DRAW_REL;
            end
            DRAW_REL:  if (!draw_done) state_next = WAIT_TICK;
            WAIT_TICK: begin
                busy = 1'b0;
                if (tick_pending && enable) state_next = ERASE;
            end
            ERASE: begin
                draw_start = 1'b1;
                color      = 1'b0;
                if (draw_done) state_next = ERASE_REL;
            end
            ERASE_REL: begin
                color = 1'b0;
                if (!draw_done) state_next = UPDATE;
            end
            UPDATE:    state_next = DRAW;
            default:   state_next = INIT;
        endcase
    end

    // Ticks arriving while busy collapse into a single pending move.
    always_ff @(posedge clk) begin
        if (reset)                                        tick_pending <= 1'b0;
        else if (tick)                                    tick_pending <= 1'b1;
        else if (state == WAIT_TICK && state_next == ERASE) tick_pending <= 1'b0;
    end

    // Count completed moves; the initial draw after reset is not a move.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
            first_draw  <= 1'b1;
        end else if (state == DRAW_REL && !draw_done) begin
            if (!first_draw) frame_count <= frame_count + 16'd1;
            first_draw <= 1'b0;
        end
    end

    // Bounce step for x: clamp to the edge and reverse when the step would cross it.
    always_comb begin
        pos_x_next = pos_x;
        dir_x_next = dir_x;
        if (dir_x == DIR_POS) begin
            if ({1'b0, pos_x} + STEP_W > XMAX) begin
                pos_x_next = XMAX[COORD_W-1:0];
                dir_x_next = DIR_NEG;
            end else begin
                pos_x_next = pos_x + STEP_C;
            end
        end else begin
            if ({1'b0, pos_x} < STEP_W) begin
                pos_x_next = '0;
                dir_x_next = DIR_POS;
            end else begin
                pos_x_next = pos_x - STEP_C;
            end
        end
    end

    // Bounce step for y, same rule against the bottom limit.
    always_comb begin
        pos_y_next = pos_y;
        dir_y_next = dir_y;
        if (dir_y == DIR_POS) begin
            if ({1'b0, pos_y} + STEP_W > YMAX) begin
                pos_y_next = YMAX[COORD_W-1:0];
                dir_y_next = DIR_NEG;
            end else begin
                pos_y_next = pos_y + STEP_C;
            end
        end else begin
            if ({1'b0, pos_y} < STEP_W) begin
                pos_y_next = '0;
                dir_y_next = DIR_POS;
            end else begin
                pos_y_next = pos_y - STEP_C;
            end
        end
    end

    // Position only changes in UPDATE, between the erase and draw passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x <= '0;
            pos_y <= '0;
            dir_x <= DIR_POS;
            dir_y <= DIR_POS;
        end else if (state == UPDATE) begin
            pos_x <= pos_x_next;
            pos_y <= pos_y_next;
            dir_x <= dir_x_next;
            dir_y <= dir_y_next;
        end
    end

endmodule

// File: tb/tb_square_animator.sv
// Bench for square_animator with a behavioural drawer and a pass-sequence scoreboard.
module tb_square_animator;

    localparam int SIZE = 10;
    localparam int SW   = 40;
    localparam int SH   = 30;
    localparam int FT   = 300;
    localparam int STEP = 1;
    localparam int XMAX = SW - 1 - SIZE;
    localparam int YMAX = SH - 1 - SIZE;
    localparam int NPIX = (SIZE + 1) * (SIZE + 1);

    logic        clk = 1'b0;
    logic        reset, enable, draw_done, draw_start, color, busy;
    logic [10:0] draw_x0, draw_y0, pos_x, pos_y;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;

    square_animator #(
        .SIZE(SIZE), .SCREEN_W(SW), .SCREEN_H(SH), .FRAME_TICKS(FT), .STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .draw_done(draw_done),
        .draw_start(draw_start), .draw_x0(draw_x0), .draw_y0(draw_y0),
        .color(color), .pos_x(pos_x), .pos_y(pos_y), .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    // ---------------- behavioural drawer ----------------
    int   dr_state = 0;      // 0 idle, 1 scanning, 2 done
    int   dr_cnt, dr_len, dr_x0, dr_y0;
    int   dr_minx, dr_maxx, dr_miny, dr_maxy;
    int   stall_max = 0;
    logic dr_done = 1'b0;
    logic stale = 1'b0;
    assign draw_done = dr_done | stale;

    always @(posedge clk) begin
        if (reset) begin
            dr_state <= 0;
            dr_done  <= 1'b0;
        end else begin
            case (dr_state)
                0: if (draw_start) begin
                    dr_state <= 1;
                    dr_x0    <= int'(draw_x0);
                    dr_y0    <= int'(draw_y0);
                    dr_cnt   <= 0;
                    dr_len   <= NPIX + int'($urandom_range(0, stall_max));
                    dr_minx  <= 99999; dr_maxx <= -1;
                    dr_miny  <= 99999; dr_maxy <= -1;
                end
                1: begin
                    if (dr_cnt < NPIX) begin
                        dr_minx <= imin(dr_minx, dr_x0 + dr_cnt % (SIZE + 1));
                        dr_maxx <= imax(dr_maxx, dr_x0 + dr_cnt % (SIZE + 1));
                        dr_miny <= imin(dr_miny, dr_y0 + dr_cnt / (SIZE + 1));
                        dr_maxy <= imax(dr_maxy, dr_y0 + dr_cnt / (SIZE + 1));
                    end
                    dr_cnt <= dr_cnt + 1;
                    if (dr_cnt == dr_len - 1) begin
                        dr_state <= 2;
                        dr_done  <= 1'b1;
                    end
                end
                default: if (!draw_start) begin
                    dr_state <= 0;
                    dr_done  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    typedef struct { int x; int y; int c; } pass_t;
    pass_t exp_q[$];
    pass_t last_draw;
    int    xs[$];
    int    ys[$];

    function automatic void step_axis(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + STEP > lim) begin p = lim; d = -1; end
            else p = p + STEP;
        end else begin
            if (p < STEP) begin p = 0; d = 1; end
            else p = p - STEP;
        end
    endfunction

    // Pass order after reset: draw(p0), then erase(pk), draw(pk+1) per move.
    task automatic build_model();
        int x = 0, y = 0, dx = 1, dy = 1;
        exp_q.delete();
        exp_q.push_back('{x: 0, y: 0, c: 1});
        repeat (200) begin
            exp_q.push_back('{x: x, y: y, c: 0});
            step_axis(x, dx, XMAX);
            step_axis(y, dy, YMAX);
            exp_q.push_back('{x: x, y: y, c: 1});
        end
    endtask

    // ---------------- monitor ----------------
    int moves = 0;
    initial begin
        logic  prev_start = 1'b0, prev_busy = 1'b1, first_period = 1'b1, stable = 1'b1;
        int    period_passes = 0, draws = 0, px0 = 0, py0 = 0, pc = 0;
        pass_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0; prev_busy = 1'b1; first_period = 1'b1;
                period_passes = 0; draws = 0;
            end else begin
                if (draw_start && !prev_start) begin
                    check("start_while_done", int'(draw_done), 0);
                    if (exp_q.size() == 0) begin
                        check("pass_queue_empty", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pass_x0", int'(draw_x0), e.x);
                        check("pass_y0", int'(draw_y0), e.y);
                        check("pass_color", int'(color), e.c);
                        if (e.c == 1) last_draw = e;
                    end
                    px0 = int'(draw_x0); py0 = int'(draw_y0); pc = int'(color);
                    stable = 1'b1;
                    period_passes++;
                    if (color) draws++;
                end else if (draw_start) begin
                    if (int'(draw_x0) != px0 || int'(draw_y0) != py0 || int'(color) != pc)
                        stable = 1'b0;
                end
                if (!draw_start && prev_start) check("pass_origin_stable", int'(stable), 1);
                if (prev_busy && !busy) begin
                    check("frame_count", int'(frame_count), draws - 1);
                    check("pos_x", int'(pos_x), last_draw.x);
                    check("pos_y", int'(pos_y), last_draw.y);
                    check("passes_per_move", period_passes, first_period ? 1 : 2);
                    xs.push_back(int'(pos_x));
                    ys.push_back(int'(pos_y));
                    first_period = 1'b0;
                    period_passes = 0;
                    moves++;
                end
                prev_start = draw_start;
                prev_busy  = busy;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_moves(input int n, input int budget);
        int target = moves + n;
        int k = 0;
        while (moves < target && k < budget) begin @(posedge clk); #1; k++; end
        check("wait_moves_timeout", int'(moves >= target), 1);
    endtask

    task automatic wait_pass(input logic c, input int budget);
        int k = 0;
        while (!(draw_start && color == c) && k < budget) begin @(posedge clk); #1; k++; end
        check("wait_pass_timeout", int'(draw_start && color == c), 1);
    endtask

    task automatic park_check(input int cycles, input int fc);
        logic seen = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; if (busy) seen = 1'b1; end
        check("parked_busy", int'(seen), 0);
        check("parked_frame_count", int'(frame_count), fc);
    endtask

    function automatic int saw_bounce(input int q[$], input int lim);
        for (int i = 0; i + 1 < q.size(); i++)
            if (q[i] == lim && q[i+1] == lim - STEP) return 1;
        return 0;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int fc0;
        logic seen;
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_draw_start", int'(draw_start), 0);
        check("rst_color", int'(color), 1);
        check("rst_busy", int'(busy), 1);
        check("rst_pos", int'({pos_x, pos_y}), 0);
        check("rst_frame_count", int'(frame_count), 0);
        build_model();
        reset = 1'b0;

        // Initial draw, then parked with enable low across three ticks.
        wait_moves(1, 1000);
        park_check(3 * FT + 10, 0);

        // First move: erase (0,0), draw (1,1) covering 1..11 on both axes.
        enable = 1'b1;
        wait_moves(1, 2000);
        check("move1_frame_count", int'(frame_count), 1);
        check("move1_cov_minx", dr_minx, 1);
        check("move1_cov_maxx", dr_maxx, 1 + SIZE);
        check("move1_cov_miny", dr_miny, 1);
        check("move1_cov_maxy", dr_maxy, 1 + SIZE);

        // Run across both edges.
        stall_max = 20;
        wait_moves(32, 32 * 700);
        check("x_edge_bounce", saw_bounce(xs, XMAX), 1);
        check("y_edge_bounce", saw_bounce(ys, YMAX), 1);

        // Passes longer than the tick period: ticks must coalesce.
        stall_max = 300;
        fc0 = int'(frame_count);
        wait_moves(8, 8 * 1200);
        check("coalesce_frame_count", int'(frame_count), fc0 + 8);

        // Drop enable during a draw pass: move completes, then parks.
        stall_max = 20;
        wait_pass(1'b0, 2000);
        wait_pass(1'b1, 2000);
        enable = 1'b0;
        fc0 = int'(frame_count);
        wait_moves(1, 1000);
        check("endrop_frame_count", int'(frame_count), (fc0 + 1) & 16'hffff);
        park_check(2 * FT, (fc0 + 1) & 16'hffff);

        // Reset during an erase pass, with a stale done held afterwards.
        enable = 1'b1;
        wait_pass(1'b0, 2000);
        repeat ($urandom_range(1, 100)) @(posedge clk);
        #1;
        check("pre_reset_in_erase", int'(draw_start && !color), 1);
        reset = 1'b1; stale = 1'b1;
        @(posedge clk); #1;
        check("abort_draw_start", int'(draw_start), 0);
        check("abort_pos", int'({pos_x, pos_y}), 0);
        check("abort_frame_count", int'(frame_count), 0);
        reset = 1'b0;
        build_model();
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (draw_start) seen = 1'b1; end
        check("init_waits_stale_done", int'(seen), 0);
        stale = 1'b0;
        wait_moves(1, 1000);
        check("post_reset_frame_count", int'(frame_count), 0);
        wait_moves(1, 2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
